// File: rtl/vexec_pkg.sv
// Shared opcode encodings, flag bit positions and FSM states for the vector execute unit.
// Optional VEXEC_XOR_OP_EN makes ALUControl 100 a legal bitwise XOR.
package vexec_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic op_legal(input logic alu_sel, input logic [2:0] ctl);
        logic ok;
        case (ctl)
            OP_ADD, OP_SUB, OP_MUL, OP_SLL, OP_SRL: ok = 1'b1;
`ifdef VEXEC_XOR_OP_EN
            OP_XOR: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok && !alu_sel;
    endfunction

endpackage

// File: rtl/vexec_lane.sv
// Combinational single-lane integer ALU producing result plus carry and overflow.
// XOR (ALUControl 100) exists only when VEXEC_XOR_OP_EN is defined.
module vexec_lane
    import vexec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             v
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [SHW-1:0]     amt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     shr;
    logic [2*WIDTH-1:0] prod;

    assign amt = b[SHW-1:0];

    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        sum    = {1'b0, a} + {1'b0, b};
        prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        // One extra bit on the far side of each shift catches the last bit shifted out.
        shl    = {1'b0, a} << amt;
        shr    = {a, 1'b0} >> amt;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = a - b;
                c      = (a >= b);
                v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
                result = prod[WIDTH-1:0];
                c      = |prod[2*WIDTH-1:WIDTH];
            end
            OP_SLL: begin
                result = shl[WIDTH-1:0];
                c      = shl[WIDTH];
            end
            OP_SRL: begin
                result = shr[WIDTH:1];
                c      = shr[0];
            end
`ifdef VEXEC_XOR_OP_EN
            OP_XOR: result = a ^ b;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/vector_exec_unit.sv
// Execute-stage ALU: 1-cycle scalar ops, lane-serial vector ops, NZCV flag register.
// Optional VEXEC_XOR_OP_EN enables ALUControl 100 = XOR.
module vector_exec_unit
    import vexec_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int LANES           = 16,
    parameter int LANE_W          = 8,
    parameter int LANES_PER_CYCLE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic                    IsVector,
    input  logic [2:0]              ALUControl,
    input  logic                    ALUSel,
    input  logic [1:0]              FlagWrite,
    input  logic [LANES*LANE_W-1:0] SrcA,
    input  logic [LANES*LANE_W-1:0] SrcB,
    input  logic                    Flush,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [LANES*LANE_W-1:0] Result,
    output logic                    Error,
    output logic [3:0]              Flags
);

    localparam int VEC_W = LANES * LANE_W;
    localparam int GRP_W = LANES_PER_CYCLE * LANE_W;
    localparam int STEPS = LANES / LANES_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t           state, next_state;
    logic [2:0]       op_q;
    logic [1:0]       fw_q;
    logic [VEC_W-1:0] a_q, b_q, res_q;
    logic             err_q;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] step_q;
    logic             acc_n, acc_z, acc_c, acc_v;

    logic busy, legal, accept, last, done_now, flag_we;
    logic [1:0] fw_sel;
    logic [3:0] f_val, vec_f;

    assign busy     = (state == BUSY);
    assign legal    = op_legal(ALUSel, ALUControl);
    assign InReady  = (state == IDLE) || ((state == DONE) && OutReady);
    assign accept   = InValid && InReady && !Flush;
    assign done_now = !legal || !IsVector || (STEPS == 1);
    assign OutValid = (state == DONE);
    assign Result   = res_q;
    assign Error    = err_q;
    assign Flags    = flags_q;

    // Lane group 0 is computed straight from the inputs on acceptance; later groups use registered operands.
    logic [2:0]       grp_op;
    logic [VEC_W-1:0] grp_src_a, grp_src_b;
    logic [CNT_W-1:0] grp_idx;
    logic [GRP_W-1:0] grp_a, grp_b;

    assign grp_op    = busy ? op_q : ALUControl;
    assign grp_src_a = busy ? a_q : SrcA;
    assign grp_src_b = busy ? b_q : SrcB;
    assign grp_idx   = busy ? step_q : '0;
    assign grp_a     = grp_src_a[int'(grp_idx)*GRP_W +: GRP_W];
    assign grp_b     = grp_src_b[int'(grp_idx)*GRP_W +: GRP_W];
    assign last      = busy ? (step_q == CNT_W'(STEPS-1)) : (STEPS == 1);

    logic [LANES_PER_CYCLE-1:0][LANE_W-1:0] grp_res;
    logic [LANES_PER_CYCLE-1:0]             grp_c, grp_v;

    for (genvar i = 0; i < LANES_PER_CYCLE; i++) begin : g_lane
        vexec_lane #(.WIDTH(LANE_W)) u_lane (
            .op     (grp_op),
            .a      (grp_a[i*LANE_W +: LANE_W]),
            .b      (grp_b[i*LANE_W +: LANE_W]),
            .result (grp_res[i]),
            .c      (grp_c[i]),
            .v      (grp_v[i])
        );
    end

    logic [DATA_W-1:0] sc_res;
    logic              sc_c, sc_v;

    vexec_lane #(.WIDTH(DATA_W)) u_scalar (
        .op     (ALUControl),
        .a      (SrcA[DATA_W-1:0]),
        .b      (SrcB[DATA_W-1:0]),
        .result (sc_res),
        .c      (sc_c),
        .v      (sc_v)
    );

    // Vector flag reduction: running accumulators merged with the current lane group.
    always_comb begin
        logic gn;
        gn = 1'b0;
        for (int i = 0; i < LANES_PER_CYCLE; i++) gn = gn | grp_res[i][LANE_W-1];
        vec_f[FLAG_N] = (busy && acc_n) || gn;
        vec_f[FLAG_Z] = (!busy || acc_z) && (grp_res == '0);
        vec_f[FLAG_C] = (busy && acc_c) || (|grp_c);
        vec_f[FLAG_V] = (busy && acc_v) || (|grp_v);
    end

    always_comb begin
        flag_we = 1'b0;
        fw_sel  = FlagWrite;
        f_val   = '0;
        if (accept && legal && !IsVector) begin
            flag_we = 1'b1;
            f_val   = {sc_res[DATA_W-1], (sc_res == '0), sc_c, sc_v};
        end else if (accept && legal && (STEPS == 1)) begin
            flag_we = 1'b1;
            f_val   = vec_f;
        end else if (busy && !Flush && last) begin
            flag_we = 1'b1;
            fw_sel  = fw_q;
            f_val   = vec_f;
        end
        flags_d = flags_q;
        if (fw_sel[1]) begin
            flags_d[FLAG_N] = f_val[FLAG_N];
            flags_d[FLAG_Z] = f_val[FLAG_Z];
        end
        if (fw_sel[0]) begin
            flags_d[FLAG_C] = f_val[FLAG_C];
            flags_d[FLAG_V] = f_val[FLAG_V];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (Flush)                            next_state = IDLE;
                else if (accept)                      next_state = done_now ? DONE : BUSY;
                else if (state == DONE && OutReady)   next_state = IDLE;
            end
            BUSY: begin
                if (Flush)     next_state = IDLE;
                else if (last) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            fw_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            flags_q <= '0;
            step_q  <= '0;
            acc_n   <= 1'b0;
            acc_z   <= 1'b0;
            acc_c   <= 1'b0;
            acc_v   <= 1'b0;
        end else begin
            if (flag_we) flags_q <= flags_d;
            if (accept) begin
                op_q   <= ALUControl;
                fw_q   <= FlagWrite;
                a_q    <= SrcA;
                b_q    <= SrcB;
                err_q  <= !legal;
                step_q <= CNT_W'(1);
                if (!legal) begin
                    res_q <= '0;
                end else if (!IsVector) begin
                    res_q <= {{(VEC_W-DATA_W){1'b0}}, sc_res};
                end else begin
                    res_q[GRP_W-1:0] <= grp_res;
                    {acc_n, acc_z, acc_c, acc_v} <= vec_f;
                end
            end else if (busy && !Flush) begin
                res_q[int'(step_q)*GRP_W +: GRP_W] <= grp_res;
                step_q <= step_q + CNT_W'(1);
                {acc_n, acc_z, acc_c, acc_v} <= vec_f;
            end
        end
    end

endmodule

// File: tb/tb_vector_exec_unit.sv
// Scoreboard bench for vector_exec_unit: directed requests push expected responses, a monitor pops and compares.
module tb_vector_exec_unit;

    logic         clk, rst_n;
    logic         InValid, InReady, IsVector, ALUSel, Flush, OutValid, OutReady, Error;
    logic [2:0]   ALUControl;
    logic [1:0]   FlagWrite;
    logic [127:0] SrcA, SrcB, Result;
    logic [3:0]   Flags;

    vector_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady), .IsVector(IsVector),
        .ALUControl(ALUControl), .ALUSel(ALUSel), .FlagWrite(FlagWrite), .SrcA(SrcA), .SrcB(SrcB),
        .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady), .Result(Result), .Error(Error),
        .Flags(Flags)
    );

    typedef struct {
        logic [127:0] res;
        logic         err;
        logic [3:0]   flags;
        int           acc;
        int           lat;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && OutValid && OutReady) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 128'(OutValid), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, Result, e.res);
                chk({e.name, "_error"}, 128'(Error), 128'(e.err));
                chk({e.name, "_flags"}, 128'(Flags), 128'(e.flags));
                if (e.lat != 0) chk({e.name, "_latency"}, 128'(cyc - e.acc), 128'(e.lat));
            end
        end
    end

    task automatic issue(input string name, input logic vec, input logic [2:0] ctl, input logic sel,
                         input logic [1:0] fw, input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] res, input logic err, input logic [3:0] fl,
                         input int lat, input bit push);
        bit got;
        exp_t e;
        got = 0;
        InValid = 1; IsVector = vec; ALUControl = ctl; ALUSel = sel; FlagWrite = fw; SrcA = a; SrcB = b;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (InReady) begin
                got = 1;
                if (push) begin
                    e.res = res; e.err = err; e.flags = fl; e.acc = cyc; e.lat = lat; e.name = name;
                    sb.push_back(e);
                end
            end
        end
        if (!got) chk({name, "_accept_timeout"}, 128'(InReady), 128'(1));
        @(posedge clk); #1;
        InValid = 0;
        // Registered operands must be immune to later input changes.
        SrcA = ~SrcA; SrcB = ~SrcB;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk({name, "_drained"}, 128'(sb.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    logic [127:0] ff16, o16, z128, inc_a, inc_r, ovf_a, ovf_r;
    logic [127:0] xor_res;
    logic         xor_err;
    logic [3:0]   xor_fl;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; rst_n = 0; InValid = 0; IsVector = 0; ALUControl = 0; ALUSel = 0; FlagWrite = 0;
        SrcA = 0; SrcB = 0; Flush = 0; OutReady = 1;
        ff16  = {16{8'hFF}};
        o16   = {16{8'h01}};
        z128  = '0;
        inc_a = 128'h0F0E0D0C0B0A09080706050403020100;
        inc_r = 128'h100F0E0D0C0B0A090807060504030201;
        ovf_a = {8'h7F, 120'h0};
        ovf_r = {8'h80, {15{8'h01}}};
`ifdef VEXEC_XOR_OP_EN
        xor_res = 128'h0FF00FF0; xor_err = 0; xor_fl = 4'b0000;
`else
        xor_res = 128'h0;        xor_err = 1; xor_fl = 4'b1001;
`endif

        repeat (2) @(posedge clk); #1;
        chk("rst_inready", 128'(InReady), 128'(1));
        chk("rst_outvalid", 128'(OutValid), 128'(0));
        chk("rst_result", Result, z128);
        chk("rst_error", 128'(Error), 128'(0));
        chk("rst_flags", 128'(Flags), 128'(0));
        rst_n = 1;
        @(posedge clk); #1;

        issue("s_sub_eq", 0, 3'b001, 0, 2'b11, {96'hDEADBEEF_CAFEF00D_12345678, 32'd5}, 128'd5,
              z128, 0, 4'b0110, 1, 1);
        drain("s_sub_eq");
        issue("v_add_wrap", 1, 3'b000, 0, 2'b11, ff16, o16, z128, 0, 4'b0110, 4, 1);
        drain("v_add_wrap");
        issue("s_preset_n", 0, 3'b000, 0, 2'b11, 128'h80000000, 128'h0, 128'h80000000, 0, 4'b1000, 1, 1);
        drain("s_preset_n");
        issue("v_mul_cv", 1, 3'b010, 0, 2'b01, {16{8'h10}}, {16{8'h10}}, z128, 0, 4'b1010, 4, 1);
        drain("v_mul_cv");
        issue("s_sll", 0, 3'b011, 0, 2'b11, 128'h80000001, 128'h21, 128'h2, 0, 4'b0010, 1, 1);
        drain("s_sll");
        issue("v_srl", 1, 3'b111, 0, 2'b11, {16{8'h83}}, {16{8'h09}}, {16{8'h41}}, 0, 4'b0010, 4, 1);
        drain("v_srl");
        issue("v_sub_borrow", 1, 3'b001, 0, 2'b11, z128, o16, ff16, 0, 4'b1000, 4, 1);
        drain("v_sub_borrow");
        issue("v_add_lanes", 1, 3'b000, 0, 2'b11, inc_a, o16, inc_r, 0, 4'b0000, 4, 1);
        drain("v_add_lanes");

        // Stall in DONE, then pop and accept in the same cycle.
        OutReady = 0;
        issue("v_stall", 1, 3'b000, 0, 2'b11, ovf_a, o16, ovf_r, 0, 4'b1001, 0, 1);
        for (int i = 0; i < 20 && !OutValid; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_outvalid", 128'(OutValid), 128'(1));
            chk("stall_result", Result, ovf_r);
            chk("stall_inready", 128'(InReady), 128'(0));
        end
        @(posedge clk); #1;
        OutReady = 1;
        issue("s_no_bubble", 0, 3'b001, 0, 2'b11, 128'd3, 128'd5, 128'hFFFFFFFE, 0, 4'b1000, 1, 1);
        drain("s_no_bubble");

        issue("s_preset_nv", 0, 3'b000, 0, 2'b11, 128'h7FFFFFFF, 128'h1, 128'h80000000, 0, 4'b1001, 1, 1);
        drain("s_preset_nv");
        issue("s_fpsel", 0, 3'b000, 1, 2'b11, 128'd1, 128'd1, z128, 1, 4'b1001, 1, 1);
        drain("s_fpsel");
        issue("v_fpsel", 1, 3'b000, 1, 2'b11, ff16, o16, z128, 1, 4'b1001, 1, 1);
        drain("v_fpsel");
        issue("s_xor", 0, 3'b100, 0, 2'b11, 128'hF0F0F0F0, 128'hFF00FF00, xor_res, xor_err, xor_fl, 1, 1);
        drain("s_xor");
        issue("s_op101", 0, 3'b101, 0, 2'b11, 128'd7, 128'd1, z128, 1, xor_fl, 1, 1);
        drain("s_op101");
        issue("s_preset2", 0, 3'b000, 0, 2'b11, 128'h7FFFFFFF, 128'h1, 128'h80000000, 0, 4'b1001, 1, 1);
        drain("s_preset2");

        // Flush during the second BUSY cycle.
        issue("v_flush", 1, 3'b000, 0, 2'b11, ff16, o16, z128, 0, 4'b0110, 4, 0);
        @(posedge clk); #1;
        Flush = 1;
        @(posedge clk); #1;
        Flush = 0;
        @(negedge clk);
        chk("flush_outvalid", 128'(OutValid), 128'(0));
        chk("flush_inready", 128'(InReady), 128'(1));
        chk("flush_flags", 128'(Flags), 128'(4'b1001));
        repeat (4) @(negedge clk);
        chk("flush_still_idle", 128'(OutValid), 128'(0));
        @(posedge clk); #1;

        // Reset pulse during the third BUSY cycle.
        issue("v_reset", 1, 3'b000, 0, 2'b11, ff16, o16, z128, 0, 4'b0110, 4, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #2;
        rst_n = 1;
        @(negedge clk);
        chk("midrst_outvalid", 128'(OutValid), 128'(0));
        chk("midrst_inready", 128'(InReady), 128'(1));
        chk("midrst_flags", 128'(Flags), 128'(0));
        chk("midrst_result", Result, z128);
        repeat (4) @(negedge clk);
        chk("midrst_still_idle", 128'(OutValid), 128'(0));
        @(posedge clk); #1;

        issue("s_fw_nz_only", 0, 3'b000, 0, 2'b10, 128'hFFFFFFFF, 128'h2, 128'h1, 0, 4'b0000, 1, 1);
        drain("s_fw_nz_only");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
